// File: rtl/bcd_countdown_timer_pkg.sv
// Shared BCD constants and digit helpers for the game's BCD datapaths.
package bcd_countdown_timer_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Any non-decimal nibble (A..F) is clamped to the largest legal digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// Free-running clock divider producing one step every TICK_CYCLES running cycles.
module tick_prescaler #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] count;

    assign tick = run && !clear && (count == LAST);

    // Holding while run is low keeps the partial period across a pause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD round timer with pause, saturating time bonus and optional auto-reload.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int TICK_CYCLES = 50000000,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    bonus,
    input  logic [4*NUM_DIGITS-1:0] bonus_value,
    output logic [4*NUM_DIGITS-1:0] time_remain,
    output logic                    tick,
    output logic                    timeout,
    output logic                    expired
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{BCD_MAX}};

    logic [W-1:0]        load_sat;
    logic [W-1:0]        bonus_sat;
    logic [W-1:0]        sum_value;
    logic [W-1:0]        dec_value;
    logic [W-1:0]        reload_value;
    logic [NUM_DIGITS:0] carry;
    logic [NUM_DIGITS:0] borrow;
    logic                run;
    logic                step_due;
    logic                count_zero;

    assign carry[0]   = 1'b0;
    assign borrow[0]  = 1'b1;
    assign count_zero = borrow[NUM_DIGITS];
    assign run        = enable && !expired;

    // A borrow that ripples past the top digit means every digit was zero.
    genvar d;
    generate
        for (d = 0; d < NUM_DIGITS; d++) begin : g_digit
            logic [3:0] cur;
            logic [4:0] raw_sum;

            assign cur                   = time_remain[4*d +: 4];
            assign load_sat[4*d +: 4]    = bcd_sat(load_value[4*d +: 4]);
            assign bonus_sat[4*d +: 4]   = bcd_sat(bonus_value[4*d +: 4]);
            assign raw_sum               = {1'b0, cur} + {1'b0, bonus_sat[4*d +: 4]} + {4'b0000, carry[d]};
            assign carry[d+1]            = (raw_sum > 5'd9);
            assign sum_value[4*d +: 4]   = carry[d+1] ? 4'(raw_sum - 5'd10) : raw_sum[3:0];
            assign borrow[d+1]           = borrow[d] && (cur == BCD_ZERO);
            assign dec_value[4*d +: 4]   = !borrow[d] ? cur :
                                           (cur == BCD_ZERO) ? BCD_MAX : cur - 4'd1;
        end
    endgenerate

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (load),
        .tick  (step_due)
    );

    // Load beats bonus beats step; a step colliding with either is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_remain  <= '0;
            reload_value <= '0;
            tick         <= 1'b0;
            timeout      <= 1'b0;
            expired      <= 1'b0;
        end else begin
            tick    <= 1'b0;
            timeout <= 1'b0;
            if (load) begin
                time_remain  <= load_sat;
                reload_value <= load_sat;
                expired      <= 1'b0;
            end else if (bonus) begin
                time_remain <= carry[NUM_DIGITS] ? ALL_NINES : sum_value;
                expired     <= 1'b0;
            end else if (step_due) begin
                if (!count_zero) begin
                    time_remain <= dec_value;
                    tick        <= 1'b1;
                    if (dec_value == '0) begin
                        timeout <= 1'b1;
                        if (!AUTO_RELOAD) begin
                            expired <= 1'b1;
                        end
                    end
                end else if (AUTO_RELOAD) begin
                    time_remain <= reload_value;
                    tick        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: one-shot and auto-reload instances against an integer model.
module tb_bcd_countdown_timer;

    localparam int ND   = 2;
    localparam int TC   = 4;
    localparam int W    = 4 * ND;
    localparam int MAXV = 99;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic         bonus = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] bonus_value = '0;
    logic [W-1:0] tr0, tr1;
    logic         tick0, timeout0, expired0;
    logic         tick1, timeout1, expired1;

    int checks = 0;
    int errors = 0;

    int m_count[2];
    int m_reload[2];
    int m_pres[2];
    bit m_tick[2];
    bit m_to[2];
    bit m_exp[2];
    bit m_step;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(ND), .TICK_CYCLES(TC), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
        .bonus(bonus), .bonus_value(bonus_value), .time_remain(tr0), .tick(tick0),
        .timeout(timeout0), .expired(expired0)
    );

    bcd_countdown_timer #(.NUM_DIGITS(ND), .TICK_CYCLES(TC), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
        .bonus(bonus), .bonus_value(bonus_value), .time_remain(tr1), .tick(tick1),
        .timeout(timeout1), .expired(expired1)
    );

    // Packed BCD to integer, treating nibbles above 9 as 9.
    function automatic int bcd2int_sat(logic [W-1:0] v);
        int r;
        int p;
        int dg;
        r = 0;
        p = 1;
        for (int d = 0; d < ND; d++) begin
            dg = int'(v[4*d +: 4]);
            if (dg > 9) dg = 9;
            r += dg * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < ND; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction

    function automatic logic [2*(W+3)-1:0] model_vec();
        return {int2bcd(m_count[0]), m_tick[0], m_to[0], m_exp[0],
                int2bcd(m_count[1]), m_tick[1], m_to[1], m_exp[1]};
    endfunction

    // Reference model in decimal arithmetic; instance 1 is the auto-reload timer.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_count[i] = 0; m_reload[i] = 0; m_pres[i] = 0;
                m_tick[i] = 0; m_to[i] = 0; m_exp[i] = 0;
            end else begin
                m_tick[i] = 0;
                m_to[i]   = 0;
                m_step    = enable && !m_exp[i] && (m_pres[i] == TC - 1);
                if (enable && !m_exp[i]) m_pres[i] = (m_pres[i] == TC - 1) ? 0 : m_pres[i] + 1;
                if (load) begin
                    m_count[i]  = bcd2int_sat(load_value);
                    m_reload[i] = m_count[i];
                    m_pres[i]   = 0;
                    m_exp[i]    = 0;
                end else if (bonus) begin
                    m_count[i] = m_count[i] + bcd2int_sat(bonus_value);
                    if (m_count[i] > MAXV) m_count[i] = MAXV;
                    m_exp[i] = 0;
                end else if (m_step) begin
                    if (m_count[i] != 0) begin
                        m_count[i] = m_count[i] - 1;
                        m_tick[i]  = 1;
                        if (m_count[i] == 0) begin
                            m_to[i] = 1;
                            if (i == 0) m_exp[i] = 1;
                        end
                    end else if (i == 1) begin
                        m_count[i] = m_reload[i];
                        m_tick[i]  = 1;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=0",
                     {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reset_release got=%h exp=%h",
                     {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
        end
    endtask

    task automatic test_countdown();
        int pulses;
        pulses = 0;
        load = 1'b1; load_value = 8'h12; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (tr0 !== 8'h12) begin
            errors++;
            $display("[TB] FAIL countdown_load got=%h exp=12", tr0);
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (timeout0) pulses++;
            checks++;
            if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL countdown_model cyc=%0d got=%h exp=%h", c,
                         {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
            end
            if (c == 4) begin
                checks++;
                if ({tr0, tick0} !== {8'h11, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL countdown_first_step got=%h/%b exp=11/1", tr0, tick0);
                end
            end
        end
        checks++;
        if ({pulses, tr0, expired0} !== {32'd1, 8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL countdown_end pulses=%0d tr=%h expired=%b exp 1/00/1", pulses, tr0, expired0);
        end
    endtask

    task automatic test_pause();
        load = 1'b1; load_value = 8'h05; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL pause_hold cyc=%0d got=%h exp=%h", c,
                         {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
            end
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (tr0 !== 8'h05) begin
            errors++;
            $display("[TB] FAIL pause_resume1 got=%h exp=05", tr0);
        end
        @(negedge clk);
        checks++;
        if ({tr0, tick0} !== {8'h04, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pause_resume2 got=%h/%b exp=04/1", tr0, tick0);
        end
    endtask

    task automatic test_bonus();
        enable = 1'b0;
        load = 1'b1; load_value = 8'h97;
        @(negedge clk);
        load = 1'b0; bonus = 1'b1; bonus_value = 8'h05;
        @(negedge clk);
        bonus = 1'b0;
        checks++;
        if (tr0 !== 8'h99) begin
            errors++;
            $display("[TB] FAIL bonus_saturate got=%h exp=99", tr0);
        end
        load = 1'b1; load_value = 8'h38;
        @(negedge clk);
        load = 1'b0; bonus = 1'b1; bonus_value = 8'h05;
        @(negedge clk);
        bonus = 1'b0;
        checks++;
        if (tr0 !== 8'h43) begin
            errors++;
            $display("[TB] FAIL bonus_carry got=%h exp=43", tr0);
        end
        load = 1'b1; load_value = 8'h01; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL bonus_expire_model cyc=%0d got=%h exp=%h", c,
                         {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
            end
        end
        checks++;
        if ({tr0, expired0} !== {8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bonus_expired got=%h/%b exp=00/1", tr0, expired0);
        end
        bonus = 1'b1; bonus_value = 8'h03;
        @(negedge clk);
        bonus = 1'b0;
        checks++;
        if ({tr0, expired0} !== {8'h03, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bonus_revive got=%h/%b exp=03/0", tr0, expired0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (tr0 !== 8'h02) begin
            errors++;
            $display("[TB] FAIL bonus_resume got=%h exp=02", tr0);
        end
    endtask

    task automatic test_collision();
        load = 1'b1; load_value = 8'h08; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tr0 !== 8'h07) begin
            errors++;
            $display("[TB] FAIL collision_pre got=%h exp=07", tr0);
        end
        repeat (3) @(negedge clk);
        load = 1'b1; load_value = 8'h30;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({tr0, tick0, timeout0} !== {8'h30, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL collision_load got=%h/%b/%b exp=30/0/0", tr0, tick0, timeout0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tr0 !== 8'h30) begin
            errors++;
            $display("[TB] FAIL collision_hold got=%h exp=30", tr0);
        end
        @(negedge clk);
        checks++;
        if ({tr0, tick0} !== {8'h29, 1'b1}) begin
            errors++;
            $display("[TB] FAIL collision_next got=%h/%b exp=29/1", tr0, tick0);
        end
    endtask

    task automatic test_auto_reload();
        int pulses;
        int exp_seen;
        pulses = 0;
        exp_seen = 0;
        load = 1'b1; load_value = 8'h02; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (timeout1) pulses++;
            if (expired1) exp_seen++;
            checks++;
            if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL reload_model cyc=%0d got=%h exp=%h", c,
                         {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
            end
            if (c == 8 || c == 12) begin
                checks++;
                if ({tr1, timeout1} !== ((c == 8) ? {8'h00, 1'b1} : {8'h02, 1'b0})) begin
                    errors++;
                    $display("[TB] FAIL reload_point cyc=%0d got=%h/%b", c, tr1, timeout1);
                end
            end
        end
        checks++;
        if ({pulses, exp_seen} !== {32'd2, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reload_summary pulses=%0d expired_cycles=%0d exp 2/0", pulses, exp_seen);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_value = 8'h41; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%h exp=0",
                     {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1});
        end
        @(negedge clk);
        rst = 1'b1;
        load = 1'b1; load_value = 8'h0F;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({tr0, tr1} !== {8'h09, 8'h09}) begin
            errors++;
            $display("[TB] FAIL sanitise got=%h/%h exp=09/09", tr0, tr1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if ({tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", c,
                         {tr0, tick0, timeout0, expired0, tr1, tick1, timeout1, expired1}, model_vec());
            end
            enable      = ($urandom_range(0, 7) != 0);
            load        = ($urandom_range(0, 39) == 0);
            bonus       = ($urandom_range(0, 24) == 0);
            load_value  = 8'($urandom_range(0, 255));
            bonus_value = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) load_value[7:4] = 4'd0;
        end
        load = 1'b0;
        bonus = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_bonus();
        test_collision();
        test_auto_reload();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised N-digit BCD countdown timer for the game's per-round time limit.
- Loads a packed BCD start value and decrements once per generated tick while enabled.
- Drives per-digit BCD outputs to the 7-segment decoders, plus timeout signalling to the game FSM.
- Adds pause/resume with fractional-tick retention, mid-game time bonus and optional auto-reload over the fixed 2-digit timer.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..6).
- TICK_CYCLES, 50000000, clk cycles per count step (1 s at 50 MHz; benches use 4).
- AUTO_RELOAD, 0, when 1 the timer reloads the last loaded value on expiry and keeps running.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- enable  input  1  count permitted while high; low = pause
- load  input  1  one-cycle strobe: capture load_value, restart prescaler
- load_value  input  4*NUM_DIGITS  packed BCD start value, digit 0 in [3:0]
- bonus  input  1  one-cycle strobe: add bonus_value to current count
- bonus_value  input  4*NUM_DIGITS  packed BCD increment
- time_remain  output  4*NUM_DIGITS  current count, packed BCD, registered
- tick  output  1  one-cycle pulse each count step (debug/LED)
- timeout  output  1  one-cycle pulse when count reaches 0 by decrement
- expired  output  1  level: count is 0 and timer has timed out since last load

Behaviour:
- Reset (rst=0, async): time_remain=0, stored reload value=0, prescaler=0, tick=0, timeout=0, expired=0.
- Input sanitising: any load_value/bonus_value digit >9 is treated as 9.
- Prescaler: counts 0..TICK_CYCLES-1 only while enable=1 and expired=0; holds its value while enable=0, so a pause keeps the fractional second. Internal step is asserted when prescaler==TICK_CYCLES-1 and the count advances; prescaler then wraps to 0.
- Priority per cycle: load > bonus > step.
- load: next cycle time_remain=sanitised load_value, reload value stored, prescaler=0, expired=0, no step/timeout that cycle. Loading 0 leaves expired=0 with count 0; the timer then idles without a timeout pulse.
- bonus: BCD add with carry across digits. Saturates at all-9s, never wraps. Clears expired; prescaler is not reset. A step coinciding with bonus is dropped.
- step when time_remain != 0: BCD decrement. A digit at 0 becomes 9 and borrows from the next higher digit. tick=1 for one cycle, registered with the new count.
- Reaching 0 by step: the same cycle that shows time_remain=0 asserts timeout=1 for one cycle.
  - AUTO_RELOAD=0: expired=1 from that cycle on; counting stops until load or bonus.
  - AUTO_RELOAD=1: on the next step time_remain returns to the stored reload value (0 → reload counts as that step); expired never sets.
- step when time_remain==0 and AUTO_RELOAD=0: no change.
- enable deasserted mid-second, then reasserted: remaining fraction is honoured, not restarted.
- Reset mid-count: immediate return to reset values.
- Latency: load/bonus visible on time_remain 1 cycle after the strobe. First step after load lands TICK_CYCLES enabled cycles later.

Decomposition:
- Shared package/include: BCD_MAX (4'd9), BCD_ZERO (4'd0), and a digit-saturate function used by all BCD blocks in the game.
- One sub-module: tick_prescaler (clk, rst, run, clear, tick), parameter TICK_CYCLES, reusable by the game's other timers.
- BCD add/decrement stays as generate loops inside bcd_countdown_timer.

Test Plan:
- NUM_DIGITS=2, TICK_CYCLES=4: load 0x12, enable=1 → time_remain steps 12,11,10,09,…,01,00 every 4 cycles. timeout pulses once at 00, expired=1, count holds at 00.
- Pause: load 0x05, enable=1 for 2 cycles, 0 for 10 cycles, then 1 → first decrement to 04 occurs 2 enabled cycles after resume.
- Bonus: count 0x97, bonus 0x05 → 0x99 (saturated). At count 0x00 with expired=1, bonus 0x03 → 0x03, expired=0, counting resumes.
- Collision: load 0x30 asserted on the exact cycle a step is due from 0x07 → time_remain=0x30, no tick, no timeout, next step 4 cycles later.
- AUTO_RELOAD=1: load 0x02 → 02,01,00 (timeout pulse), 02,01,00 (timeout pulse)…, expired stays 0.
- Async reset asserted mid-count at 0x41 → outputs 0 immediately, without waiting for a clock edge. Load 0x0F sanitises to 0x09.
